// File: rtl/lsu_bus_arbiter.sv
// rtl/lsu_bus_arbiter.sv - two-master round-robin arbiter for the LSU load/store bus with watchdog
module lsu_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    // master 0 (core LSU)
    input  logic                m0_rready,
    output logic                m0_rvalid,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_strb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    // master 1 (debug / DMA)
    input  logic                m1_rready,
    output logic                m1_rvalid,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_strb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    // slave
    output logic                s_rready,
    input  logic                s_rvalid,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_strb,
    input  logic [DATA_W-1:0]   s_rdata,
    // current owner {m1,m0}
    output logic [1:0]          grant
);

    localparam int  STRB_W  = DATA_W / 8;
    localparam bit  WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam int  TO_LAST = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam int  CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t             state_q;
    logic [1:0]         grant_q;
    logic               last_q;     // 1 = m1 was granted most recently
    logic [CNT_W-1:0]   cnt_q;

    logic               req0;
    logic               req1;
    logic               pick_m1_d;
    logic               granted;
    logic               sel_m1;
    logic               cur_rready;
    logic               cur_wvalid;
    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  cur_wdata;
    logic [STRB_W-1:0]  cur_strb;
    logic               cur_active;
    logic               handshake;
    logic               wd_expired;
    logic               forced;
    logic               done;
    logic               resp_fire;

    assign req0 = m0_rready | m0_wvalid;
    assign req1 = m1_rready | m1_wvalid;

    // Arbitration decision taken in IDLE: a lone requester wins, a tie goes to the
    // master that was not granted last.
    always_comb begin
        pick_m1_d = 1'b0;
        if (req0 && req1) begin
            pick_m1_d = ~last_q;
        end else begin
            pick_m1_d = req1;
        end
    end

    // Select the granted master's request and work out how this grant cycle ends.
    always_comb begin
        granted    = (state_q != ST_IDLE);
        sel_m1     = (state_q == ST_GNT1);
        cur_rready = 1'b0;
        cur_wvalid = 1'b0;
        cur_addr   = '0;
        cur_wdata  = '0;
        cur_strb   = '0;
        if (state_q == ST_GNT0) begin
            cur_rready = m0_rready;
            cur_wvalid = m0_wvalid;
            cur_addr   = m0_addr;
            cur_wdata  = m0_wdata;
            cur_strb   = m0_strb;
        end else if (state_q == ST_GNT1) begin
            cur_rready = m1_rready;
            cur_wvalid = m1_wvalid;
            cur_addr   = m1_addr;
            cur_wdata  = m1_wdata;
            cur_strb   = m1_strb;
        end
        cur_active = cur_rready | cur_wvalid;
        // A write takes priority over a read from the same master, so the
        // write handshake is the one that completes the grant.
        handshake  = cur_wvalid ? s_wready : s_rvalid;
        wd_expired = WD_EN && (cnt_q == CNT_W'(TO_LAST));
        // A real response in the last watchdog cycle wins over the forced error.
        forced     = granted && cur_active && !handshake && wd_expired;
        done       = granted && cur_active && handshake;
        resp_fire  = done || forced;
    end

    // Slave side mirrors the granted master; requests are withdrawn on a forced completion.
    always_comb begin
        s_rready = 1'b0;
        s_wvalid = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_strb   = '0;
        if (granted) begin
            s_rready = cur_rready && !cur_wvalid && !forced;
            s_wvalid = cur_wvalid && !forced;
            s_addr   = cur_addr;
            s_wdata  = cur_wdata;
            s_strb   = cur_strb;
        end
    end

    // Route responses only to the granted master; the other side stays quiet.
    always_comb begin
        m0_rvalid = 1'b0;
        m0_wready = 1'b0;
        m0_err    = 1'b0;
        m0_rdata  = '0;
        m1_rvalid = 1'b0;
        m1_wready = 1'b0;
        m1_err    = 1'b0;
        m1_rdata  = '0;
        if (granted && !sel_m1) begin
            m0_rvalid = resp_fire && !cur_wvalid;
            m0_wready = resp_fire && cur_wvalid;
            m0_err    = forced;
            m0_rdata  = forced ? '0 : s_rdata;
        end else if (granted && sel_m1) begin
            m1_rvalid = resp_fire && !cur_wvalid;
            m1_wready = resp_fire && cur_wvalid;
            m1_err    = forced;
            m1_rdata  = forced ? '0 : s_rdata;
        end
    end

    assign grant = grant_q;

    // Grant FSM: IDLE arbitrates, GNTn holds until handshake, watchdog or request drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (req0 || req1) begin
                        state_q <= pick_m1_d ? ST_GNT1 : ST_GNT0;
                        grant_q <= pick_m1_d ? 2'b10 : 2'b01;
                        last_q  <= pick_m1_d;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (!cur_active || resp_fire) begin
                        state_q <= ST_IDLE;
                        grant_q <= 2'b00;
                        cnt_q   <= '0;
                    end else if (WD_EN) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// tb/tb_lsu_bus_arbiter.sv - randomized self-checking bench for lsu_bus_arbiter
module tb_lsu_bus_arbiter;

    localparam int TO     = 4;
    localparam int NCYC   = 3000;

    logic        clk;
    logic        rst_n;
    logic        m_rr    [2];
    logic        m_wv    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_strb  [2];
    logic        s_rvalid;
    logic        s_wready;
    logic [31:0] s_rdata;

    logic        m0_rvalid, m0_wready, m0_err, m1_rvalid, m1_wready, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_rready, s_wvalid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_strb;
    logic [1:0]  grant;

    lsu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_rready(m_rr[0]), .m0_rvalid(m0_rvalid), .m0_wvalid(m_wv[0]), .m0_wready(m0_wready),
        .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_strb(m_strb[0]), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_rready(m_rr[1]), .m1_rvalid(m1_rvalid), .m1_wvalid(m_wv[1]), .m1_wready(m1_wready),
        .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_strb(m_strb[1]), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_rready(s_rready), .s_rvalid(s_rvalid), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_strb(s_strb), .s_rdata(s_rdata),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [69:0] obs_s  = {s_rready, s_wvalid, s_addr, s_wdata, s_strb};
    wire [34:0] obs_m0 = {m0_rvalid, m0_wready, m0_err, m0_rdata};
    wire [34:0] obs_m1 = {m1_rvalid, m1_wready, m1_err, m1_rdata};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    // Transaction-level model: who owns the bus, how long it has owned it, who went last.
    int own, age, last;
    int n_own, n_age, n_last;
    logic [1:0]  exp_grant;
    logic [69:0] exp_s;
    logic [34:0] exp_m [2];
    logic        e_rv [2];
    logic        e_wr [2];

    task automatic model_reset();
        own = -1; age = 0; last = 1;
        n_own = -1; n_age = 0; n_last = 1;
        for (int i = 0; i < 2; i++) begin e_rv[i] = 0; e_wr[i] = 0; end
    endtask

    task automatic model_eval();
        bit want0, want1, active, resp, expired, forced, fire, wr;
        int n, pick;
        exp_grant = 2'b00; exp_s = '0; exp_m[0] = '0; exp_m[1] = '0;
        e_rv[0] = 0; e_rv[1] = 0; e_wr[0] = 0; e_wr[1] = 0;
        n_age = 0; n_last = last; n_own = -1;
        if (own < 0) begin
            want0 = m_rr[0] | m_wv[0];
            want1 = m_rr[1] | m_wv[1];
            if (want0 || want1) begin
                pick   = (want0 && want1) ? 1 - last : (want0 ? 0 : 1);
                n_own  = pick;
                n_last = pick;
            end
        end else begin
            n         = own;
            exp_grant = (n == 0) ? 2'b01 : 2'b10;
            wr        = m_wv[n];
            active    = m_rr[n] | m_wv[n];
            resp      = wr ? s_wready : s_rvalid;
            expired   = (age + 1 == TO);
            forced    = active && !resp && expired;
            fire      = active && (resp || expired);
            exp_s     = {m_rr[n] && !wr && !forced, wr && !forced, m_addr[n], m_wdata[n], m_strb[n]};
            exp_m[n]  = {fire && !wr, fire && wr, forced, forced ? 32'h0 : s_rdata};
            e_rv[n]   = fire && !wr;
            e_wr[n]   = fire && wr;
            n_own     = (fire || !active) ? -1 : n;
            n_age     = age + 1;
        end
    endtask

    task automatic new_op(input int i, input int kind);
        m_rr[i]    = (kind != 1);
        m_wv[i]    = (kind != 0);
        m_addr[i]  = $urandom;
        m_wdata[i] = $urandom;
        m_strb[i]  = 4'($urandom);
    endtask

    task automatic update_masters();
        for (int i = 0; i < 2; i++) begin
            if (e_wr[i]) m_wv[i] = 1'b0;
            else if (e_rv[i]) m_rr[i] = 1'b0;
            if (!m_rr[i] && !m_wv[i]) begin
                if ($urandom_range(0, 2) == 0) new_op(i, int'($urandom_range(0, 2)));
            end else if ($urandom_range(0, 24) == 0) begin
                m_rr[i] = 1'b0;
                m_wv[i] = 1'b0;
            end
        end
    endtask

    task automatic drive_slave();
        s_rvalid = ($urandom_range(0, 2) == 0);
        s_wready = ($urandom_range(0, 2) == 0);
        s_rdata  = $urandom;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_grant"}, 128'(grant), 128'(0));
        check_eq({tag, "_s"}, 128'(obs_s), 128'(0));
        check_eq({tag, "_m0"}, 128'(obs_m0), 128'(0));
        check_eq({tag, "_m1"}, 128'(obs_m1), 128'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) new_op(i, 1);
        drive_slave();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        model_eval();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            own = n_own; age = n_age; last = n_last;
            update_masters();
            drive_slave();
            if (cyc % 500 == 250) begin
                #2 rst_n = 1'b0;
                #1 check_zero("async_rst");
                @(posedge clk);
                #1;
                model_reset();
                for (int i = 0; i < 2; i++) new_op(i, 1);
                rst_n = 1'b1;
            end
            @(negedge clk);
            model_eval();
            check_eq("grant", 128'(grant), 128'(exp_grant));
            check_eq("slave_bus", 128'(obs_s), 128'(exp_s));
            check_eq("m0_resp", 128'(obs_m0), 128'(exp_m[0]));
            check_eq("m1_resp", 128'(obs_m1), 128'(exp_m[1]));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_bus_arbiter.md
Name: lsu_bus_arbiter

Overview:
Two-master, one-slave arbiter for the core's LSU load/store handshake bus. Master 0 is the core's LSU port; master 1 is a secondary master such as a debug or DMA engine. It grants one whole transaction at a time with round-robin fairness and locks the grant until completion. A watchdog completes stalled transactions with an error so the core never hangs on an unmapped address.

Parameters:
ADDR_W, 32, address width of masters and slave.
DATA_W, 32, data width; strobe width is DATA_W/8.
TIMEOUT_CYCLES, 64, max cycles in a grant without slave response; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m0_rready, m1_rready  in  1  read request; held with addr until mN_rvalid
m0_rvalid, m1_rvalid  out  1  read data valid, one-cycle pulse
m0_wvalid, m1_wvalid  in  1  write request; held with addr/data/strb until mN_wready
m0_wready, m1_wready  out  1  write accepted, one-cycle pulse
m0_addr, m1_addr  in  ADDR_W  byte address
m0_wdata, m1_wdata  in  DATA_W  store data
m0_strb, m1_strb  in  DATA_W/8  byte strobes
m0_rdata, m1_rdata  out  DATA_W  load data, valid with mN_rvalid
m0_err, m1_err  out  1  timeout error pulse, coincident with the forced response
s_rready  out  1  read request to slave
s_rvalid  in  1  slave read data valid
s_wvalid  out  1  write request to slave
s_wready  in  1  slave write accepted
s_addr  out  ADDR_W
s_wdata  out  DATA_W
s_strb  out  DATA_W/8
s_rdata  in  DATA_W
grant  out  2  one-hot current grant {m1,m0}; 00 when idle

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset forces state IDLE, grant=00, last_grant=m1 (so m0 wins the first tie), timeout counter=0.
- Reset values: all slave-side outputs 0; all mN_rvalid/mN_wready/mN_err 0; mN_rdata 0.
- States and transitions:
  - IDLE -> GNT0/GNT1 on the clk edge where any request (rready|wvalid) is present.
  - GNT0/GNT1 -> IDLE on the edge of the slave handshake, the timeout, or a request drop.
- Arbitration:
  - Only one master requesting: that master is granted.
  - Both requesting: the master not equal to last_grant is granted. last_grant updates on entry to a grant state.
  - The grant decision is registered, so one cycle is added versus a direct connection. Minimum read/write latency seen by the master is 1 + slave latency.
- In GNTn, s_* outputs combinationally mirror master n's request, address, data and strobe. In IDLE all s_* outputs are 0.
- Simultaneous read and write request from the same master: s_wvalid is forwarded and s_rready forced 0. The write completes first; the read is re-arbitrated afterwards.
- s_rvalid/s_wready are routed only to the granted master. The other master's rvalid/wready stay 0. s_rdata is routed to mN_rdata of the granted master only; non-granted mN_rdata is 0.
- Completion:
  - Slave handshake (s_rvalid for read, s_wready for write) in GNTn returns the arbiter to IDLE next cycle.
  - There is one mandatory idle cycle between transactions, so back-to-back requests from one master alternate with the other master if it is waiting.
- Request drop: if the granted master deasserts both requests before the response, go to IDLE. A slave response arriving in that same cycle is not forwarded.
- Watchdog:
  - The counter clears on grant entry and increments each cycle in GNTn without a handshake.
  - When the counter reaches TIMEOUT_CYCLES-1 with no response, the arbiter, in that cycle:
    - pulses mN_rvalid (read) or mN_wready (write) together with mN_err;
    - drives mN_rdata=0 and deasserts s_* requests;
    - goes to IDLE.
  - A real slave response in the timeout cycle takes precedence: normal completion, err=0.
- Slave responses while IDLE are ignored.
- Mid-transaction reset: immediate return to reset values. The slave must tolerate an aborted request.

Test Plan:
- Single read: m0 read addr 0x100, slave s_rvalid 2 cycles after s_rready with rdata 0xCAFEF00D -> grant=01 one cycle after the request; m0_rvalid pulses one cycle with rdata 0xCAFEF00D; then grant=00.
- Tie fairness: m0 and m1 both write continuously from reset, slave wready immediate -> grants alternate 01, 00, 10, 00, 01…, starting with m0; each master receives exactly one wready per grant.
- Same-master read+write: m1 asserts wvalid and rready at addr 0x20, strb 0xF, wdata 0x12345678 -> s_wvalid=1 with s_rready=0 first; after wready, a second grant carries s_rready.
- Timeout: TIMEOUT_CYCLES=4, m0 reads and the slave never responds -> on the 4th grant cycle m0_rvalid=1, m0_err=1, m0_rdata=0; grant=00 next cycle.
- Response on timeout cycle: same setup but s_rvalid asserted on the 4th cycle with 0xA5A5A5A5 -> m0_err=0, rdata 0xA5A5A5A5.
- Reset mid-write: assert rst_n low during GNT1 -> all outputs 0 asynchronously; after release with both masters requesting, m0 is granted first.
